// File: rtl/basic_axi_pkg.sv
// Shared types and defaults for the basic AXI adder and its stream packer.
package basic_axi_pkg;

    localparam int C_DATA_WIDTH_DEF = 32;
    localparam int TID_WIDTH_DEF    = 8;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_PAD = 2'd2
    } pack_state_t;

endpackage

// File: rtl/axis_operand_packer_if.sv
// AXI-Stream bundle (valid/ready/data/last/id) with master and slave views.
interface axis_operand_packer_if #(
    parameter int DW = 32,
    parameter int TW = 8
) ();
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic [TW-1:0] tid;

    modport master (output tvalid, tdata, tlast, tid, input tready);
    modport slave  (input tvalid, tdata, tlast, tid, output tready);
endinterface

// File: rtl/axis_operand_packer_out_reg.sv
// One-stage AXIS output register: load when free, hold under backpressure, drain on handshake.
// Latency 1 cycle from load; free is combinational on m.tready so drain+load gives no bubble.
module axis_out_reg #(
    parameter int DW = 64,
    parameter int TW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DW-1:0]         load_data,
    input  logic                  load_last,
    input  logic [TW-1:0]         load_tid,
    output logic                  free,
    axis_operand_packer_if.master m
);

    assign free = !m.tvalid || m.tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m.tvalid <= 1'b0;
            m.tdata  <= '0;
            m.tlast  <= 1'b0;
            m.tid    <= '0;
        end else if (load) begin
            m.tvalid <= 1'b1;
            m.tdata  <= load_data;
            m.tlast  <= load_last;
            m.tid    <= load_tid;
        end else if (m.tready) begin
            m.tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_operand_packer.sv
// Packs pairs of operand beats into one {B,A} beat, padding odd packets with B=0.
// Pair out 1 cycle after B/pad; S_A always accepts one A, S_B/S_PAD stall on output backpressure.
module axis_operand_packer
    import basic_axi_pkg::*;
#(
    parameter int C_DATA_WIDTH = C_DATA_WIDTH_DEF,
    parameter int TID_WIDTH    = TID_WIDTH_DEF
) (
    input  logic                 aclk,
    input  logic                 areset,
    axis_operand_packer_if.slave  s_axis,
    axis_operand_packer_if.master m_axis,
    output logic                 odd_err,
    output logic [31:0]          pairs_sent
);

    pack_state_t                 state, nstate;
    logic [C_DATA_WIDTH-1:0]     a_q;
    logic [TID_WIDTH-1:0]        pkt_cnt;
    logic                        s_rdy, accept, free, m_hs;
    logic                        load, pad;
    logic [2*C_DATA_WIDTH-1:0]   load_data;
    logic                        load_last;
    logic [TID_WIDTH-1:0]        load_tid;
    logic                        unused_s_tid;

    assign unused_s_tid = ^s_axis.tid;

    // Ready is a function of state and downstream only, never of s_axis.tvalid.
    assign s_rdy         = !areset && ((state == S_A) || ((state == S_B) && free));
    assign s_axis.tready = s_rdy;
    assign accept        = s_axis.tvalid && s_rdy;
    assign m_hs          = m_axis.tvalid && m_axis.tready;

    // A pair loaded while the previous packet's last beat drains belongs to the next packet.
    assign load_tid = (m_hs && m_axis.tlast) ? pkt_cnt + TID_WIDTH'(1) : pkt_cnt;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= S_A;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate    = state;
        load      = 1'b0;
        pad       = 1'b0;
        load_data = {{C_DATA_WIDTH{1'b0}}, a_q};
        load_last = 1'b1;
        case (state)
            S_A: begin
                if (accept) begin
                    nstate = s_axis.tlast ? S_PAD : S_B;
                end
            end
            S_B: begin
                if (accept) begin
                    load      = 1'b1;
                    load_data = {s_axis.tdata, a_q};
                    load_last = s_axis.tlast;
                    nstate    = S_A;
                end
            end
            S_PAD: begin
                if (free) begin
                    load   = 1'b1;
                    pad    = 1'b1;
                    nstate = S_A;
                end
            end
            default: nstate = S_A;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            a_q        <= '0;
            pkt_cnt    <= '0;
            pairs_sent <= '0;
            odd_err    <= 1'b0;
        end else begin
            if ((state == S_A) && accept) begin
                a_q <= s_axis.tdata;
            end
            if (m_hs) begin
                pairs_sent <= pairs_sent + 32'd1;
                if (m_axis.tlast) begin
                    pkt_cnt <= pkt_cnt + TID_WIDTH'(1);
                end
            end
            odd_err <= pad;
        end
    end

    axis_out_reg #(
        .DW (2*C_DATA_WIDTH),
        .TW (TID_WIDTH)
    ) u_out_reg (
        .clk       (aclk),
        .rst       (areset),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .load_tid  (load_tid),
        .free      (free),
        .m         (m_axis)
    );

endmodule
